// File: rtl/boot_ram.sv
// -----------------------------------------------------------------------------
// boot_ram
//   256 x 8 boot memory with a built-in image loader. After reset the array is
//   optionally zeroed (CLEAR). A byte-stream loader then fills it starting at
//   START_ADDR (LOAD). Finally the CPU is released to run from it (RUN). A
//   reload can be requested from RUN with a one-cycle load_req pulse.
//
// Parameters
//   CLEAR_ON_RESET  1: zero all locations after reset before loading; 0: skip
//   START_ADDR      first address written by the loader
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid        loader byte valid
//   in_data[7:0]    loader byte
//   in_last         marks the final byte of the image (qualified by in_valid)
//   in_ready        loader may transfer this cycle (LOAD only)
//   load_req        reload request pulse, honoured in RUN only
//   ram_addr[7:0]   CPU address
//   ram_data[7:0]   CPU write data
//   ram_we          CPU write enable, honoured in RUN only
//   ram_out[7:0]    combinational read data, mem[ram_addr]
//   cpu_run         high only in RUN
//   load_count[7:0] bytes accepted in the current load, saturating at 255
//   overflow        sticky: image ran past 256 bytes without in_last
// -----------------------------------------------------------------------------
module boot_ram #(
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0] START_ADDR     = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       load_req,
  input  logic [7:0] ram_addr,
  input  logic [7:0] ram_data,
  input  logic       ram_we,
  output logic [7:0] ram_out,
  output logic       cpu_run,
  output logic [7:0] load_count,
  output logic       overflow
);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_LOAD;

  logic [1:0] r_state;
  logic [7:0] r_clr_ptr;
  logic [7:0] r_load_ptr;
  logic [7:0] r_load_count;
  logic       r_overflow;
  logic [7:0] r_mem [256];

  logic       w_xfer;
  logic       w_last_slot;
  logic       w_we;
  logic [7:0] w_waddr;
  logic [7:0] w_wdata;

  // Gated by rst_n so the loader is held off during reset even when the
  // reset state is LOAD (CLEAR_ON_RESET = 0).
  assign in_ready    = (r_state == ST_LOAD) && rst_n;
  assign w_xfer      = in_valid && in_ready;
  // A saturated counter at a transfer means this is byte 256.
  assign w_last_slot = (r_load_count == 8'hFF);

  assign cpu_run    = (r_state == ST_RUN);
  assign load_count = r_load_count;
  assign overflow   = r_overflow;
  assign ram_out    = r_mem[ram_addr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RESET;
      r_clr_ptr    <= 8'h00;
      r_load_ptr   <= START_ADDR;
      r_load_count <= 8'h00;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 8'd1;
          if (r_clr_ptr == 8'hFF) begin
            r_state      <= ST_LOAD;
            r_load_ptr   <= START_ADDR;
            r_load_count <= 8'h00;
            r_overflow   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            // Pointer wraps naturally mod 256; after 256 bytes it is back at
            // START_ADDR. Overflow is judged only from the count.
            r_load_ptr <= r_load_ptr + 8'd1;
            if (!w_last_slot) begin
              r_load_count <= r_load_count + 8'd1;
            end
            if (in_last) begin
              r_state <= ST_RUN;
            end else if (w_last_slot) begin
              r_overflow <= 1'b1;
              r_state    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (load_req) begin
            r_state      <= ST_LOAD;
            r_load_ptr   <= START_ADDR;
            r_load_count <= 8'h00;
            r_overflow   <= 1'b0;
          end
        end
        default: r_state <= ST_RESET;
      endcase
    end
  end

  // Single write port; the state decides who owns it, so the clearer, the
  // loader and the CPU can never collide.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_clr_ptr;
    w_wdata = 8'h00;
    case (r_state)
      ST_CLEAR: begin
        w_we    = rst_n;
        w_waddr = r_clr_ptr;
        w_wdata = 8'h00;
      end
      ST_LOAD: begin
        w_we    = w_xfer;
        w_waddr = r_load_ptr;
        w_wdata = in_data;
      end
      ST_RUN: begin
        w_we    = ram_we;
        w_waddr = ram_addr;
        w_wdata = ram_data;
      end
      default: begin
        w_we    = 1'b0;
        w_waddr = r_clr_ptr;
        w_wdata = 8'h00;
      end
    endcase
  end

  // NOTE: the storage array has no reset; contents are only zeroed by the
  // CLEAR state, which keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

endmodule

// File: tb/tb_boot_ram.sv
`timescale 1ns/1ps
module tb_boot_ram;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, rst_n_b;
  logic       in_valid, in_last, load_req, ram_we;
  logic [7:0] in_data, ram_addr, ram_data;

  logic       a_in_ready, a_cpu_run, a_overflow;
  logic [7:0] a_ram_out, a_load_count;
  logic       b_in_ready, b_cpu_run, b_overflow;
  logic [7:0] b_ram_out, b_load_count;

  // Default configuration: clear on reset, load from 0.
  boot_ram u_dut_a (
    .clk(clk), .rst_n(rst_n_a),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(a_in_ready),
    .load_req(load_req), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .ram_out(a_ram_out), .cpu_run(a_cpu_run), .load_count(a_load_count), .overflow(a_overflow)
  );

  // No clear, load from FE (wrap-around image).
  boot_ram #(.CLEAR_ON_RESET(1'b0), .START_ADDR(8'hFE)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(b_in_ready),
    .load_req(load_req), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .ram_out(b_ram_out), .cpu_run(b_cpu_run), .load_count(b_load_count), .overflow(b_overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model_mem [256];
  logic [7:0] model_ptr;
  logic [7:0] exp_q [$];

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_out;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Count rising edges from reset release until the loader is admitted.
  task automatic wait_clear(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!a_in_ready && cycles < 400);
  endtask

  // One loader transfer (preceded by gap idle cycles); model follows the image.
  task automatic load_byte(input logic [7:0] d, input logic last, input int gap);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    model_mem[model_ptr] = d;
    model_ptr++;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Read through the scoreboard: expectation queued at drive, popped at sample.
  task automatic do_read(input string name, input logic sel, input logic [7:0] addr,
                         input logic [7:0] exp);
    logic [7:0] got;
    logic [7:0] want;
    @(negedge clk);
    ram_addr = addr;
    exp_q.push_back(exp);
    #1;
    got  = sel ? b_ram_out : a_ram_out;
    want = exp_q.pop_front();
    check(name, got, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;

    vecs[0] = '{1'b1, 8'h40, 8'h5A, 8'h5A};
    vecs[1] = '{1'b1, 8'h00, 8'h3C, 8'h3C};
    vecs[2] = '{1'b0, 8'h01, 8'hFF, 8'h0B};
    vecs[3] = '{1'b1, 8'hFF, 8'h81, 8'h81};
    vecs[4] = '{1'b0, 8'h40, 8'h00, 8'h5A};
    vecs[5] = '{1'b0, 8'h02, 8'h00, 8'hC5};

    rst_n_a = 1'b0; rst_n_b = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    load_req = 1'b0; ram_addr = 8'h00; ram_data = 8'h00; ram_we = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    model_ptr = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready_a", a_in_ready, 1'b0);
    check("rst_cpu_run_a", a_cpu_run, 1'b0);
    check("rst_load_count_a", a_load_count, 8'h00);
    check("rst_overflow_a", a_overflow, 1'b0);
    check("rst_in_ready_b", b_in_ready, 1'b0);

    // CLEAR lasts exactly 256 cycles
    rst_n_a = 1'b1;
    wait_clear(cyc);
    check("clear_cycles", cyc, 256);
    do_read("clear_mem_ff", 1'b0, 8'hFF, 8'h00);

    // Gapped 3-byte image
    @(negedge clk);
    load_byte(8'hA9, 1'b0, 0);
    load_byte(8'h0B, 1'b0, 2);
    check("run_before_last", a_cpu_run, 1'b0);
    load_byte(8'hC5, 1'b1, 1);
    check("run_after_last", a_cpu_run, 1'b1);
    check("count_3", a_load_count, 8'h03);
    check("in_ready_run", a_in_ready, 1'b0);
    do_read("img_0", 1'b0, 8'h00, model_mem[0]);
    do_read("img_1", 1'b0, 8'h01, model_mem[1]);
    do_read("img_2", 1'b0, 8'h02, model_mem[2]);

    // CPU writes/reads in RUN from the vector table
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ram_we = vecs[i].we; ram_addr = vecs[i].addr; ram_data = vecs[i].data;
      if (vecs[i].we) model_mem[vecs[i].addr] = vecs[i].data;
      exp_q.push_back(vecs[i].exp_out);
      @(negedge clk);
      ram_we = 1'b0;
      #1;
      check($sformatf("vec%0d", i), a_ram_out, exp_q.pop_front());
    end

    // load_req together with a CPU write: write lands, state goes to LOAD
    @(negedge clk);
    load_req = 1'b1; ram_we = 1'b1; ram_addr = 8'h10; ram_data = 8'h77;
    model_mem[8'h10] = 8'h77;
    @(negedge clk);
    load_req = 1'b0; ram_we = 1'b0;
    check("reload_in_ready", a_in_ready, 1'b1);
    check("reload_cpu_run", a_cpu_run, 1'b0);
    check("reload_count", a_load_count, 8'h00);
    do_read("reload_write", 1'b0, 8'h10, 8'h77);

    // CPU write in LOAD is ignored
    @(negedge clk);
    ram_we = 1'b1; ram_addr = 8'h40; ram_data = 8'h00;
    @(negedge clk);
    ram_we = 1'b0;
    do_read("load_cpu_write_ignored", 1'b0, 8'h40, 8'h5A);

    // load_req in LOAD is ignored
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("load_req_in_load", a_in_ready, 1'b1);

    // 256 bytes without last -> overflow; 257th refused
    model_ptr = 8'h00;
    for (int i = 0; i < 255; i++) load_byte(8'(i) ^ 8'h5A, 1'b0, 0);
    check("ovf_255_flag", a_overflow, 1'b0);
    check("ovf_255_run", a_cpu_run, 1'b0);
    check("ovf_255_count", a_load_count, 8'hFF);
    load_byte(8'hFF ^ 8'h5A, 1'b0, 0);
    check("ovf_256_flag", a_overflow, 1'b1);
    check("ovf_256_run", a_cpu_run, 1'b1);
    check("ovf_256_count", a_load_count, 8'hFF);
    in_valid = 1'b1; in_data = 8'hEE;
    check("ovf_257_ready", a_in_ready, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("ovf_257_count", a_load_count, 8'hFF);
    do_read("ovf_mem_00", 1'b0, 8'h00, model_mem[8'h00]);
    do_read("ovf_mem_80", 1'b0, 8'h80, model_mem[8'h80]);
    do_read("ovf_mem_ff", 1'b0, 8'hFF, model_mem[8'hFF]);

    // 256th byte carries last -> RUN without overflow
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("reload2_ovf_cleared", a_overflow, 1'b0);
    model_ptr = 8'h00;
    for (int i = 0; i < 255; i++) load_byte(8'(i), 1'b0, 0);
    load_byte(8'hFF, 1'b1, 0);
    check("last256_flag", a_overflow, 1'b0);
    check("last256_run", a_cpu_run, 1'b1);
    check("last256_count", a_load_count, 8'hFF);

    // Reset mid-LOAD: asynchronous abort, CLEAR restarts
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    model_ptr = 8'h00;
    load_byte(8'h12, 1'b0, 0);
    load_byte(8'h34, 1'b0, 0);
    check("midload_count", a_load_count, 8'h02);
    #2;
    rst_n_a = 1'b0;
    #1;
    check("async_in_ready", a_in_ready, 1'b0);
    check("async_count", a_load_count, 8'h00);
    check("async_cpu_run", a_cpu_run, 1'b0);
    @(negedge clk);
    rst_n_a = 1'b1;
    wait_clear(cyc);
    check("reclear_cycles", cyc, 256);
    do_read("reclear_mem_40", 1'b0, 8'h40, 8'h00);
    do_read("reclear_mem_01", 1'b0, 8'h01, 8'h00);

    // Second configuration: no clear, START_ADDR = FE, image wraps to 00
    @(negedge clk);
    rst_n_a = 1'b0;
    rst_n_b = 1'b1;
    @(negedge clk);
    check("b_ready_no_clear", b_in_ready, 1'b1);
    check("b_count_start", b_load_count, 8'h00);
    load_byte(8'h11, 1'b0, 0);
    load_byte(8'h22, 1'b0, 1);
    load_byte(8'h33, 1'b1, 0);
    check("b_cpu_run", b_cpu_run, 1'b1);
    check("b_count", b_load_count, 8'h03);
    check("b_overflow", b_overflow, 1'b0);
    check("a_held_in_reset", a_in_ready, 1'b0);
    do_read("b_mem_fe", 1'b1, 8'hFE, 8'h11);
    do_read("b_mem_ff", 1'b1, 8'hFF, 8'h22);
    do_read("b_mem_00", 1'b1, 8'h00, 8'h33);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
